// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared operation/state types and decode helpers for the multiply/divide unit
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        MULT, MULTU, DIV, DIVU, DMULT, DMULTU, DDIV, DDIVU, MTHI, MTLO
    } muldiv_op_t;

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} muldiv_state_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {DIV, DIVU, DDIV, DDIVU};
    endfunction

    function automatic logic op_is_dw(muldiv_op_t op);
        return op inside {DMULT, DMULTU, DDIV, DDIVU};
    endfunction

    function automatic logic op_is_signed(muldiv_op_t op);
        return op inside {MULT, DIV, DMULT, DDIV};
    endfunction

    function automatic logic op_is_muldiv(muldiv_op_t op);
        return op inside {MULT, MULTU, DIV, DIVU, DMULT, DMULTU, DDIV, DDIVU};
    endfunction

    function automatic logic [63:0] sext32(logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add for multiply or restoring shift-subtract for divide
//   op       : operation in flight (selects add or subtract)
//   acc, q   : partial product high/low half, or partial remainder / dividend-quotient shifter
//   operand  : multiplicand or divisor magnitude
//   acc_next, q_next : state after this step
module muldiv_step
    import muldiv_unit_pkg::*;
(
    input  muldiv_op_t  op,
    input  logic [63:0] acc,
    input  logic [63:0] q,
    input  logic [63:0] operand,
    output logic [63:0] acc_next,
    output logic [63:0] q_next
);
    logic [64:0] sum;
    logic [64:0] sh;
    logic [63:0] diff;
    logic        ge;

    always_comb begin
        sum = {1'b0, acc} + (q[0] ? {1'b0, operand} : 65'd0);
        sh = {acc, q[63]};
        ge = sh >= {1'b0, operand};
        // remainder stays below the divisor, so the low 64 bits of the difference are exact
        diff = sh[63:0] - operand;
        acc_next = op_is_div(op) ? (ge ? diff : sh[63:0]) : sum[64:1];
        q_next = op_is_div(op) ? {q[62:0], ge} : {sum[0], q[63:1]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS64 multiply/divide unit with HI/LO registers
//   clock, reset (async, active low)
//   start, op, A_data, B_data : issue an operation (accepted only in IDLE)
//   flush      : squash the in-flight operation
//   hilo_read  : decode holds MFHI/MFLO
//   busy, done, stall_request : status; hi, lo : result registers
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  muldiv_op_t  op,
    input  logic [63:0] A_data,
    input  logic [63:0] B_data,
    input  logic        flush,
    input  logic        hilo_read,
    output logic        busy,
    output logic        done,
    output logic        stall_request,
    output logic [63:0] hi,
    output logic [63:0] lo
);
    muldiv_state_t state, state_next;
    muldiv_op_t    cur_op;
    logic [5:0]    count;
    logic [63:0]   acc, q, b_reg, acc_step, q_step;
    logic          a_neg, b_neg;

    logic          sgn, dw, accept, md_go, div_zero, a_sn, b_sn;
    logic [63:0]   a_ext, b_ext, a_mag, b_mag;

    logic          c_dw, c_div, neg, zdiv;
    logic [127:0]  prod, sprod;
    logic [63:0]   quo, rem, squo, srem, dvd, sdvd, res_hi, res_lo;

    muldiv_step u_step (
        .op       (cur_op),
        .acc      (acc),
        .q        (q),
        .operand  (b_reg),
        .acc_next (acc_step),
        .q_next   (q_step)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;
    assign stall_request = busy & (start | hilo_read);

    always_comb begin
        sgn = op_is_signed(op);
        dw = op_is_dw(op);
        a_ext = dw ? A_data : {{32{sgn & A_data[31]}}, A_data[31:0]};
        b_ext = dw ? B_data : {{32{sgn & B_data[31]}}, B_data[31:0]};
        a_sn = sgn & a_ext[63];
        b_sn = sgn & b_ext[63];
        a_mag = a_sn ? -a_ext : a_ext;
        b_mag = b_sn ? -b_ext : b_ext;
        accept = state == IDLE && start && !flush;
        md_go = accept && op_is_muldiv(op);
        div_zero = op_is_div(op) && b_mag == '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = md_go ? (div_zero ? FIXUP : ITER) : IDLE;
            ITER:  state_next = flush ? IDLE : (count == '0 ? FIXUP : ITER);
            FIXUP: state_next = flush ? IDLE : DONE;
            DONE:  state_next = IDLE;
        endcase
    end

    // word multiplies leave the 64-bit product split as acc[31:0]:q[63:32];
    // word divides keep the quotient in q[31:0] and remainder in acc[31:0]
    always_comb begin
        c_dw = op_is_dw(cur_op);
        c_div = op_is_div(cur_op);
        neg = a_neg ^ b_neg;
        zdiv = b_reg == '0;
        prod = c_dw ? {acc, q} : {64'd0, acc[31:0], q[63:32]};
        sprod = neg ? -prod : prod;
        quo = c_dw ? q : {32'd0, q[31:0]};
        rem = c_dw ? acc : {32'd0, acc[31:0]};
        squo = neg ? -quo : quo;
        srem = a_neg ? -rem : rem;
        dvd = c_dw ? q : {32'd0, q[63:32]};
        sdvd = a_neg ? -dvd : dvd;
        res_lo = !c_div ? (c_dw ? sprod[63:0] : sext32(sprod[31:0])) :
                 zdiv ? '1 : (c_dw ? squo : sext32(squo[31:0]));
        res_hi = !c_div ? (c_dw ? sprod[127:64] : sext32(sprod[63:32])) :
                 c_dw ? (zdiv ? sdvd : srem) : sext32(zdiv ? sdvd[31:0] : srem[31:0]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cur_op <= MULT;
            count <= '0;
            acc <= '0;
            q <= '0;
            b_reg <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            state <= state_next;
            if (md_go) begin
                cur_op <= op;
                a_neg <= a_sn;
                b_neg <= b_sn;
                b_reg <= b_mag;
                acc <= '0;
                // word dividends start at the top so their MSB shifts out first
                q <= (op_is_div(op) && !dw) ? {a_mag[31:0], 32'd0} : a_mag;
                count <= dw ? 6'd63 : 6'd31;
            end else if (state == ITER) begin
                acc <= acc_step;
                q <= q_step;
                count <= count - 6'd1;
            end
            if (accept && op == MTHI) hi <= A_data;
            if (accept && op == MTLO) lo <= A_data;
            if (state == FIXUP && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    muldiv_op_t  op = MULT;
    logic [63:0] A_data = '0;
    logic [63:0] B_data = '0;
    logic        flush = 1'b0;
    logic        hilo_read = 1'b0;
    logic        busy, done, stall_request;
    logic [63:0] hi, lo;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_unit dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .A_data        (A_data),
        .B_data        (B_data),
        .flush         (flush),
        .hilo_read     (hilo_read),
        .busy          (busy),
        .done          (done),
        .stall_request (stall_request),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    task automatic issue(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eh, input logic [63:0] el, input int lat, input bit push);
        @(negedge clock);
        op = o;
        A_data = a;
        B_data = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        if (push) sb.push_back('{eh, el, lat, cyc});
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout waiting for done, %0d results pending", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        hilo_read = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall_request, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        hilo_read = 1'b0;
        reset = 1'b1;

        issue(MTHI, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, 0, 0);
        chk("mthi_hi", hi, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("mthi_busy", busy, 0);
        issue(MTLO, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 0);
        chk("mtlo_lo", lo, 64'h1234_5678_9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 64'hAAAA_BBBB_CCCC_DDDD);

        issue(DIV, 64'hFFFF_FFF9, 2, ONES, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1);
        repeat (3) @(negedge clock);
        hilo_read = 1'b1;
        #1 chk("hilo_read_stall", stall_request, 1);
        chk("busy_in_iter", busy, 1);
        hilo_read = 1'b0;
        #1 chk("idle_inputs_no_stall", stall_request, 0);
        op = MTHI;
        A_data = 64'h5555;
        start = 1'b1;
        #1 chk("start_busy_stall", stall_request, 1);
        @(posedge clock);
        #1 chk("mthi_ignored_busy", hi, 64'hAAAA_BBBB_CCCC_DDDD);
        start = 1'b0;
        drain();

        issue(MULT, 64'h4000_0000, 4, 1, 0, 34, 1);
        drain();
        issue(MULT, 64'h1234_5678_FFFF_FFFD, 5, ONES, 64'hFFFF_FFFF_FFFF_FFF1, 34, 1);
        drain();
        issue(MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 34, 1);
        drain();
        issue(DIV, 7, 64'hFFFF_FFFE, 1, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1);
        drain();
        issue(DIV, 64'h8000_0000, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFF_8000_0000, 34, 1);
        drain();
        issue(DMULTU, ONES, 2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1);
        drain();
        issue(DMULT, 64'hFFFF_FFFF_FFFF_FFFE, 3, ONES, 64'hFFFF_FFFF_FFFF_FFFA, 66, 1);
        drain();
        issue(DDIV, 64'h8000_0000_0000_0000, ONES, 0, 64'h8000_0000_0000_0000, 66, 1);
        drain();
        issue(DDIVU, 100, 7, 2, 14, 66, 1);
        drain();
        issue(DIV, 64'hFFFF_FFF9, 0, 64'hFFFF_FFFF_FFFF_FFF9, ONES, 2, 1);
        drain();
        issue(DIVU, 5, 0, 5, ONES, 2, 1);
        drain();

        issue(DMULT, 3, 5, 0, 0, 0, 0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        chk("flush_idle", busy, 0);
        chk("flush_hi_kept", hi, 5);
        chk("flush_lo_kept", lo, ONES);
        seen = 0;
        repeat (70) @(negedge clock) if (done) seen++;
        chk("flush_no_done", 64'(seen), 0);
        chk("flush_hi_after", hi, 5);

        @(negedge clock);
        op = MULT;
        A_data = 2;
        B_data = 3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clock);
        #1 chk("flush_beats_start", busy, 0);
        start = 1'b0;
        flush = 1'b0;

        issue(DDIV, 1000, 3, 0, 0, 0, 0);
        repeat (20) @(negedge clock);
        hilo_read = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        chk("async_reset_stall", stall_request, 0);
        chk("async_reset_hi", hi, 0);
        chk("async_reset_lo", lo, 0);
        hilo_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", busy, 0);
        issue(DDIVU, 100, 7, 2, 14, 66, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
